// File: rtl/fetch_unit_basic_pkg.sv
// Shared front-end definitions: reset PC, default queue depth and the memory
// request/response message formats used by fetch, cache and memory models.
package fetch_unit_basic_pkg;

    localparam logic [31:0] RST_ADDR      = 32'h0000_0200;
    localparam int unsigned MAX_IN_FLIGHT = 2;
    localparam logic [31:0] INST_BYTES    = 32'd4;

    typedef struct packed {
        logic [31:0] addr;
    } mem_req_msg_t;

    typedef struct packed {
        logic [31:0] data;
    } mem_resp_msg_t;

    // Sequential fetch advances one word; wraps naturally at 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/fetch_unit_basic_if.sv
// Bundle of the fetch stage's three streams (mem request, mem response,
// decode) plus the downstream squash/redirect.
interface fetch_unit_basic_if;

    // Every stream transfers exactly on a cycle where val & rdy are both high
    // at the rising clock edge; rdy may depend combinationally on val.
    logic        mem_req_val;
    logic        mem_req_rdy;
    logic [31:0] mem_req_addr;

    logic        mem_resp_val;
    logic        mem_resp_rdy;
    logic [31:0] mem_resp_data;

    logic        D_val;
    logic        D_rdy;
    logic [31:0] D_inst;
    logic [31:0] D_pc;

    logic        squash_val;
    logic [31:0] squash_target;

    modport master (
        output mem_req_val, mem_req_addr,
        input  mem_req_rdy,
        input  mem_resp_val, mem_resp_data,
        output mem_resp_rdy,
        output D_val, D_inst, D_pc,
        input  D_rdy,
        input  squash_val, squash_target
    );

    modport slave (
        input  mem_req_val, mem_req_addr,
        output mem_req_rdy,
        output mem_resp_val, mem_resp_data,
        input  mem_resp_rdy,
        input  D_val, D_inst, D_pc,
        output D_rdy,
        output squash_val, squash_target
    );

endinterface

// File: rtl/fetch_unit_basic_pc_queue.sv
// fetch_pc_queue: small synchronous FIFO holding the PCs of outstanding
// fetch requests in issue order; head is the PC of the next response.
module fetch_pc_queue #(
    parameter int unsigned p_depth = 2,
    parameter int unsigned p_width = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [p_width-1:0] push_data,
    output logic [p_width-1:0] head,
    output logic               full,
    output logic               empty
);

    localparam int unsigned PW = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int unsigned CW = $clog2(p_depth + 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(p_depth);

    logic [p_width-1:0] mem [p_depth];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               do_push;
    logic               do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(p_depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit_basic.sv
// Fetch stage: issues sequential instruction fetches, pairs in-order responses
// with their PCs and forwards them to decode; squash discards stale responses.
module fetch_unit_basic
    import fetch_unit_basic_pkg::*;
#(
    parameter logic [31:0] p_rst_addr      = RST_ADDR,
    parameter int unsigned p_max_in_flight = MAX_IN_FLIGHT
) (
    input  logic                clk,
    input  logic                rst,
    fetch_unit_basic_if.master  bus
);

    localparam int unsigned   CW      = $clog2(p_max_in_flight + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(p_max_in_flight);

    logic [31:0]   pc;
    logic [CW-1:0] in_flight;
    logic [CW-1:0] drop_cnt;

    logic          req_fire;
    logic          resp_fire;
    logic          drop_mode;
    logic          q_full;
    logic          q_empty;
    logic [31:0]   q_head;

    mem_req_msg_t  req_msg;
    mem_resp_msg_t resp_msg;

    assign req_msg.addr  = pc;
    assign resp_msg.data = bus.mem_resp_data;

    // Non-zero drop_cnt means the responses at the head belong to squashed requests.
    assign drop_mode = (drop_cnt != '0);

    assign bus.mem_req_val  = ~rst & ~bus.squash_val & (in_flight < MAX_CNT) & ~q_full;
    assign bus.mem_req_addr = req_msg.addr;

    assign bus.mem_resp_rdy = ~rst & (drop_mode | bus.D_rdy | bus.squash_val);

    // Zero-latency pass-through from memory response to decode.
    assign bus.D_val  = ~rst & ~drop_mode & ~q_empty & bus.mem_resp_val & ~bus.squash_val;
    assign bus.D_inst = resp_msg.data;
    assign bus.D_pc   = q_head;

    assign req_fire  = bus.mem_req_val  & bus.mem_req_rdy;
    assign resp_fire = bus.mem_resp_val & bus.mem_resp_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= p_rst_addr;
            in_flight <= '0;
            drop_cnt  <= '0;
        end else begin
            case ({req_fire, resp_fire})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: ;
            endcase

            if (bus.squash_val) begin
                // Everything still outstanding after this edge is stale.
                pc       <= bus.squash_target;
                drop_cnt <= in_flight - CW'(resp_fire);
            end else begin
                if (req_fire) begin
                    pc <= next_pc(pc);
                end
                if (drop_mode && resp_fire) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
            end
        end
    end

    fetch_pc_queue #(
        .p_depth (p_max_in_flight),
        .p_width (32)
    ) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .pop       (resp_fire),
        .push_data (pc),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

endmodule

// File: tb/tb_fetch_unit_basic.sv
// Directed bench for fetch_unit_basic with an in-order, 1-cycle memory model
// whose instruction word for address A is ~A.
module tb_fetch_unit_basic;

    logic clk;
    logic rst;

    fetch_unit_basic_if bus ();

    fetch_unit_basic u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Memory model: accepts every request, answers in order one cycle later
    // while mem_en is high.
    logic [31:0] mem_q[$];
    logic        model_val;
    logic [31:0] model_data;
    logic        mem_en;

    assign bus.mem_resp_val  = mem_en & model_val;
    assign bus.mem_resp_data = model_data;

    always @(posedge clk) begin
        if (rst) begin
            mem_q.delete();
            model_val  <= 1'b0;
            model_data <= '0;
        end else begin
            if (bus.mem_resp_val && bus.mem_resp_rdy) void'(mem_q.pop_front());
            if (bus.mem_req_val && bus.mem_req_rdy) mem_q.push_back(bus.mem_req_addr);
            model_val  <= (mem_q.size() != 0);
            model_data <= (mem_q.size() != 0) ? ~mem_q[0] : '0;
        end
    end

    // Transaction logs for the scoreboards.
    logic [31:0] req_log[$];
    logic [31:0] d_log[$];
    logic [31:0] exp_q[$];

    always @(posedge clk) begin
        if (!rst && bus.mem_req_val && bus.mem_req_rdy) req_log.push_back(bus.mem_req_addr);
        if (!rst && bus.D_val && bus.D_rdy) d_log.push_back(bus.D_pc);
    end

    typedef struct {
        logic        sq;
        logic [31:0] tgt;
        logic        drdy;
        logic        rrdy;
        logic        en;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_dv;
        logic [31:0] e_pc;
        logic        e_resp_rdy;
    } vec_t;

    function automatic vec_t mk(input logic sq, input logic [31:0] tgt, input logic drdy,
                                input logic rrdy, input logic en, input logic e_rv,
                                input logic [31:0] e_addr, input logic e_dv,
                                input logic [31:0] e_pc, input logic e_resp_rdy);
        vec_t v;
        v.sq = sq; v.tgt = tgt; v.drdy = drdy; v.rrdy = rrdy; v.en = en;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_dv = e_dv; v.e_pc = e_pc;
        v.e_resp_rdy = e_resp_rdy;
        return v;
    endfunction

    localparam int NV = 25;
    vec_t vecs[NV];

    task automatic drive(input logic sq, input logic [31:0] tgt, input logic drdy,
                         input logic rrdy, input logic en);
        bus.squash_val    = sq;
        bus.squash_target = tgt;
        bus.D_rdy         = drdy;
        bus.mem_req_rdy   = rrdy;
        mem_en            = en;
    endtask

    initial begin
        //               sq  tgt           drdy rr  en   rv  addr          dv  pc            resp_rdy
        vecs[0]  = mk(0, 32'h0,        1, 1, 1,  1, 32'h0000_0200, 0, 32'h0,        1);
        vecs[1]  = mk(0, 32'h0,        1, 1, 1,  1, 32'h0000_0204, 1, 32'h0000_0200, 1);
        vecs[2]  = mk(0, 32'h0,        1, 1, 1,  1, 32'h0000_0208, 1, 32'h0000_0204, 1);
        vecs[3]  = mk(0, 32'h0,        0, 1, 1,  1, 32'h0000_020C, 1, 32'h0000_0208, 0);
        vecs[4]  = mk(0, 32'h0,        0, 1, 1,  0, 32'h0,        1, 32'h0000_0208, 0);
        vecs[5]  = mk(0, 32'h0,        1, 1, 1,  0, 32'h0,        1, 32'h0000_0208, 1);
        vecs[6]  = mk(0, 32'h0,        0, 1, 1,  1, 32'h0000_0210, 1, 32'h0000_020C, 0);
        vecs[7]  = mk(1, 32'h0000_1000, 1, 1, 1,  0, 32'h0,        0, 32'h0,        1);
        vecs[8]  = mk(0, 32'h0,        1, 1, 1,  1, 32'h0000_1000, 0, 32'h0,        1);
        vecs[9]  = mk(0, 32'h0,        1, 1, 1,  1, 32'h0000_1004, 1, 32'h0000_1000, 1);
        vecs[10] = mk(0, 32'h0,        1, 1, 1,  1, 32'h0000_1008, 1, 32'h0000_1004, 1);
        vecs[11] = mk(0, 32'h0,        1, 1, 0,  1, 32'h0000_100C, 0, 32'h0,        1);
        vecs[12] = mk(0, 32'h0,        1, 1, 0,  0, 32'h0,        0, 32'h0,        1);
        vecs[13] = mk(1, 32'h0000_2000, 1, 1, 0,  0, 32'h0,        0, 32'h0,        1);
        vecs[14] = mk(0, 32'h0,        1, 1, 1,  0, 32'h0,        0, 32'h0,        1);
        vecs[15] = mk(0, 32'h0,        1, 1, 1,  1, 32'h0000_2000, 0, 32'h0,        1);
        vecs[16] = mk(0, 32'h0,        1, 1, 1,  1, 32'h0000_2004, 1, 32'h0000_2000, 1);
        vecs[17] = mk(0, 32'h0,        1, 1, 1,  1, 32'h0000_2008, 1, 32'h0000_2004, 1);
        vecs[18] = mk(1, 32'h0000_3000, 1, 1, 1,  0, 32'h0,        0, 32'h0,        1);
        vecs[19] = mk(1, 32'h0000_4000, 1, 1, 1,  0, 32'h0,        0, 32'h0,        1);
        vecs[20] = mk(0, 32'h0,        1, 1, 1,  1, 32'h0000_4000, 0, 32'h0,        1);
        vecs[21] = mk(0, 32'h0,        1, 1, 1,  1, 32'h0000_4004, 1, 32'h0000_4000, 1);
        vecs[22] = mk(0, 32'h0,        1, 0, 1,  1, 32'h0000_4008, 1, 32'h0000_4004, 1);
        vecs[23] = mk(0, 32'h0,        1, 1, 1,  1, 32'h0000_4008, 0, 32'h0,        1);
        vecs[24] = mk(0, 32'h0,        1, 1, 1,  1, 32'h0000_400C, 1, 32'h0000_4008, 1);

        // Reset: all handshake outputs low while rst is held.
        rst = 1'b1;
        drive(0, 32'h0, 1, 1, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("rst mem_req_val", {31'b0, bus.mem_req_val}, 32'd0);
        chk("rst mem_resp_rdy", {31'b0, bus.mem_resp_rdy}, 32'd0);
        chk("rst D_val", {31'b0, bus.D_val}, 32'd0);

        // Table-driven run: streaming, decode stall, squashes, req backpressure.
        @(negedge clk);
        rst = 1'b0;
        req_log.delete();
        d_log.delete();
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].sq, vecs[i].tgt, vecs[i].drdy, vecs[i].rrdy, vecs[i].en);
            #1;
            chk($sformatf("v%0d mem_req_val", i), {31'b0, bus.mem_req_val}, {31'b0, vecs[i].e_rv});
            if (vecs[i].e_rv)
                chk($sformatf("v%0d mem_req_addr", i), bus.mem_req_addr, vecs[i].e_addr);
            chk($sformatf("v%0d D_val", i), {31'b0, bus.D_val}, {31'b0, vecs[i].e_dv});
            if (vecs[i].e_dv) begin
                chk($sformatf("v%0d D_pc", i), bus.D_pc, vecs[i].e_pc);
                chk($sformatf("v%0d D_inst", i), bus.D_inst, ~vecs[i].e_pc);
            end
            chk($sformatf("v%0d mem_resp_rdy", i), {31'b0, bus.mem_resp_rdy}, {31'b0, vecs[i].e_resp_rdy});
            if (vecs[i].e_dv && vecs[i].drdy) exp_q.push_back(vecs[i].e_pc);
            @(negedge clk);
        end

        // Decode-side scoreboard: every delivered PC, in order, nothing extra.
        chk("decode count", d_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < d_log.size(); i++)
            chk($sformatf("decode pc %0d", i), d_log[i], exp_q[i]);

        // Memory never responds: exactly two requests, then the stage stalls.
        rst = 1'b1;
        drive(0, 32'h0, 1, 1, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req_log.delete();
        exp_q.delete();
        exp_q.push_back(32'h0000_0200);
        exp_q.push_back(32'h0000_0204);
        repeat (6) @(negedge clk);
        #1;
        chk("no-resp req count", req_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < req_log.size(); i++)
            chk($sformatf("no-resp req addr %0d", i), req_log[i], exp_q[i]);
        chk("no-resp mem_req_val", {31'b0, bus.mem_req_val}, 32'd0);
        chk("no-resp D_val", {31'b0, bus.D_val}, 32'd0);

        // Mid-stream reset with two outstanding requests.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst mem_req_val", {31'b0, bus.mem_req_val}, 32'd0);
        chk("midrst mem_resp_rdy", {31'b0, bus.mem_resp_rdy}, 32'd0);
        chk("midrst D_val", {31'b0, bus.D_val}, 32'd0);
        @(negedge clk);
        #1;
        chk("midrst+1 mem_req_val", {31'b0, bus.mem_req_val}, 32'd0);
        chk("midrst+1 D_val", {31'b0, bus.D_val}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_en = 1'b1;
        #1;
        chk("post-rst mem_req_val", {31'b0, bus.mem_req_val}, 32'd1);
        chk("post-rst mem_req_addr", bus.mem_req_addr, 32'h0000_0200);
        chk("post-rst D_val", {31'b0, bus.D_val}, 32'd0);
        @(negedge clk);
        #1;
        chk("post-rst D_val 2", {31'b0, bus.D_val}, 32'd1);
        chk("post-rst D_pc", bus.D_pc, 32'h0000_0200);
        chk("post-rst D_inst", bus.D_inst, 32'hFFFF_FDFF);
        chk("post-rst mem_req_addr 2", bus.mem_req_addr, 32'h0000_0204);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
